// File: rtl/systolic_result_drain.sv
// Drains an NxN systolic array row by row onto a valid/ready stream; compute_done -> out_valid in 2 cycles, 2 cycles per row.
// Outputs hold while out_valid && !out_ready; define SA_DRAIN_RELU_EN to zero negative words on capture.
package systolic_array_pkg;
    typedef logic signed [15:0] word_t;
endpackage

module systolic_result_drain
    import systolic_array_pkg::*;
#(
    parameter int N = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  compute_done,
    input  logic                  array_stall,
    input  word_t [N-1:0]         y_out,
    output logic [$clog2(N)-1:0]  y_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output word_t [N-1:0]         out_data,
    output logic [$clog2(N)-1:0]  out_row,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  overrun_clr
);
    localparam int IW = $clog2(N);
    localparam int W  = $bits(word_t);
    localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STALL = 2'd1,
        READ       = 2'd2,
        SEND       = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_row_cnt;
    logic                r_out_valid;
    word_t [N-1:0]       r_out_data;
    logic [IW-1:0]       r_out_row;
    logic                r_out_last;
    logic                r_overrun;
    logic                w_start;
    logic                w_capture;
    logic                w_hs;
    logic                w_is_last;
    logic                w_overrun_evt;
    word_t [N-1:0]       w_capture_dat;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_capture     = 1'b0;
        w_hs          = 1'b0;
        w_is_last     = (r_row_cnt == LAST_ROW);
        w_overrun_evt = compute_done && (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (compute_done) begin
                    w_start     = 1'b1;
                    w_state_nxt = array_stall ? WAIT_STALL : READ;
                end
            end
            WAIT_STALL: begin
                if (!array_stall) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (!array_stall) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = w_is_last ? IDLE : READ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_capture_dat = y_out;
        for (int j = 0; j < N; j++) begin
`ifdef SA_DRAIN_RELU_EN
            if (y_out[j][W-1]) begin
                w_capture_dat[j] = '0;
            end
`else
            w_capture_dat[j] = y_out[j];
`endif
        end
    end

    // row_cnt returns to 0 when the frame ends so y_index only moves on leaving SEND
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_row_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_start) begin
                r_row_cnt <= '0;
            end
            if (w_capture) begin
                r_out_data  <= w_capture_dat;
                r_out_row   <= r_row_cnt;
                r_out_valid <= 1'b1;
                r_out_last  <= w_is_last;
            end
            if (w_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_row_cnt   <= w_is_last ? '0 : r_row_cnt + 1'b1;
            end
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign y_index   = r_row_cnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_row   = r_out_row;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain at N=4 with a behavioural array model.
module tb_systolic_result_drain;
    import systolic_array_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          compute_done;
    logic          array_stall;
    word_t [N-1:0] y_out;
    logic [1:0]    y_index;
    logic          out_valid;
    logic          out_ready;
    word_t [N-1:0] out_data;
    logic [1:0]    out_row;
    logic          out_last;
    logic          busy;
    logic          overrun;
    logic          overrun_clr;

    logic [63:0]   mem     [N];
    logic [63:0]   row_exp [N];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    assign y_out = mem[y_index];

    systolic_result_drain #(.N(N)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .compute_done(compute_done),
        .array_stall (array_stall),
        .y_out       (y_out),
        .y_index     (y_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
    endtask

    task automatic check_row(input int k);
        check($sformatf("valid_r%0d", k), 64'(out_valid), 64'd1);
        check($sformatf("row_r%0d", k), 64'(out_row), 64'(k));
        check($sformatf("data_r%0d", k), out_data, row_exp[k]);
        check($sformatf("last_r%0d", k), 64'(out_last), 64'(k == N - 1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) tick();
        check("idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        row_exp[0] = 64'h0003_0002_0001_0000;
        row_exp[1] = 64'h000d_000c_000b_000a;
        row_exp[2] = 64'h0017_0016_0015_0014;
        row_exp[3] = 64'h0021_0020_001f_001e;
        for (int k = 0; k < N; k++) mem[k] = row_exp[k];
        n_rst = 1'b0; compute_done = 1'b0; array_stall = 1'b0;
        out_ready = 1'b1; overrun_clr = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_row", 64'(out_row), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_yidx", 64'(y_index), 64'd0);
        n_rst = 1'b1;
        tick();

        // basic frame
        pulse_done();
        for (int k = 0; k < N; k++) begin
            check($sformatf("basic_read_valid%0d", k), 64'(out_valid), 64'd0);
            check($sformatf("basic_yidx%0d", k), 64'(y_index), 64'(k));
            check($sformatf("basic_busy%0d", k), 64'(busy), 64'd1);
            tick();
            check_row(k);
            tick();
        end
        check("basic_busy_end", 64'(busy), 64'd0);
        check("basic_valid_end", 64'(out_valid), 64'd0);

        // backpressure on row 1
        pulse_done();
        tick();
        check_row(0);
        tick();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_row(1);
            check("bp_yidx", 64'(y_index), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        check_row(1);
        tick();
        check("bp_gap_valid", 64'(out_valid), 64'd0);
        tick();
        check_row(2);
        wait_idle();

        // stall at start and during row 2 read
        array_stall = 1'b1;
        pulse_done();
        for (int i = 0; i < 3; i++) begin
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_valid", 64'(out_valid), 64'd0);
            tick();
        end
        array_stall = 1'b0;
        tick();
        check("stall_read_valid", 64'(out_valid), 64'd0);
        tick();
        check_row(0);
        tick(); tick();
        check_row(1);
        tick();
        array_stall = 1'b1;
        mem[2] = 64'hdead_beef_dead_beef;
        for (int i = 0; i < 2; i++) begin
            check("stall2_valid", 64'(out_valid), 64'd0);
            check("stall2_yidx", 64'(y_index), 64'd2);
            tick();
        end
        array_stall = 1'b0;
        mem[2] = row_exp[2];
        check("stall2_fall_valid", 64'(out_valid), 64'd0);
        tick();
        check_row(2);
        tick(); tick();
        check_row(3);
        tick();
        check("stall_busy_end", 64'(busy), 64'd0);

        // overrun during row 1
        pulse_done();
        tick(); tick();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        check("ovr_set", 64'(overrun), 64'd1);
        check_row(1);
        tick(); tick();
        check_row(2);
        tick(); tick();
        check_row(3);
        tick();
        check("ovr_frame_end", 64'(busy), 64'd0);
        tick(); tick(); tick();
        check("ovr_sticky", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", 64'(overrun), 64'd0);
        pulse_done();
        compute_done = 1'b1; overrun_clr = 1'b1;
        tick();
        compute_done = 1'b0; overrun_clr = 1'b0;
        check("ovr_set_wins", 64'(overrun), 64'd1);
        wait_idle();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr2", 64'(overrun), 64'd0);

        // reset during SEND of row 2
        pulse_done();
        tick(); tick();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick(); tick();
        check_row(2);
        check("mid_ovr", 64'(overrun), 64'd1);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_data", out_data, 64'd0);
        check("mrst_row", 64'(out_row), 64'd0);
        check("mrst_last", 64'(out_last), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_overrun", 64'(overrun), 64'd0);
        check("mrst_yidx", 64'(y_index), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_quiet", 64'(out_valid), 64'd0);
        end
        pulse_done();
        check("restart_yidx", 64'(y_index), 64'd0);
        tick();
        check_row(0);
        wait_idle();

        // signed capture / ReLU
        mem[0] = 64'hffff_0000_0007_fffb;
        pulse_done();
        tick();
`ifdef SA_DRAIN_RELU_EN
        check("relu_data", out_data, 64'h0000_0000_0007_0000);
`else
        check("raw_data", out_data, 64'hffff_0000_0007_fffb);
`endif
        wait_idle();
        mem[0] = row_exp[0];

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
